// File: rtl/pc_ctrl_itr.sv
// Program counter with a LIFO call stack and NITR vectored, edge-captured,
// maskable, fixed-priority interrupt channels (no nesting).
module pc_ctrl_itr #(
    parameter int MINSTW  = 9,
    parameter int SDEPTH  = 5,
    parameter int NITR    = 4,
    parameter int ITRBASE = 1,
    parameter int ITRSTP  = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic                         jmp,
    input  logic                         call,
    input  logic                         ret,
    input  logic                         reti,
    input  logic [MINSTW-1:0]            tgt,
    input  logic [NITR-1:0]              itr_req,
    input  logic [NITR-1:0]              itr_mask,
    input  logic                         clr,
    output logic [MINSTW-1:0]            instr_addr,
    output logic [NITR-1:0]              itr_ack,
    output logic                         itr_busy,
    output logic [$clog2(SDEPTH+1)-1:0]  stk_lvl,
    output logic                         stk_ovf,
    output logic                         stk_unf
);

    localparam int LW = $clog2(SDEPTH + 1);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_ISR = 1'b1
    } state_t;

    function automatic logic [MINSTW-1:0] vec_of(input int ch);
        return MINSTW'(ITRBASE + ch * ITRSTP);
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [MINSTW-1:0]   r_pc;
    logic [MINSTW-1:0]   w_pc_nxt;
    logic [MINSTW-1:0]   w_pc_inc;
    logic [LW-1:0]       r_lvl;
    logic [LW-1:0]       w_lvl_nxt;
    logic [MINSTW-1:0]   r_stk [SDEPTH];
    logic                w_wr_en;
    logic [LW-1:0]       w_wr_idx;
    logic [NITR-1:0]     r_req_d;
    logic [NITR-1:0]     r_pend;
    logic [NITR-1:0]     r_ack;
    logic [NITR-1:0]     w_edge;
    logic [NITR-1:0]     w_elig;
    logic [NITR-1:0]     w_sel;
    logic [NITR-1:0]     w_ack_nxt;
    logic [MINSTW-1:0]   w_vec;
    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_ovf_set;
    logic                w_unf_set;
    logic                r_ovf;
    logic                r_unf;

    assign w_pc_inc = r_pc + MINSTW'(1);
    assign w_full   = (r_lvl == LW'(SDEPTH));
    assign w_empty  = (r_lvl == '0);
    assign w_edge   = itr_req & ~r_req_d;
    assign w_elig   = r_pend & ~itr_mask;
    // Isolate the lowest set bit: lowest channel index has highest priority.
    assign w_sel    = w_elig & (~w_elig + NITR'(1));

    always_comb begin
        w_vec = '0;
        for (int i = NITR - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_vec = vec_of(i);
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        w_pc_nxt    = r_pc;
        w_lvl_nxt   = r_lvl;
        w_state_nxt = r_state;
        w_ack_nxt   = '0;
        w_push      = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_idx    = r_lvl;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;

        if (!stall) begin
            if (reti || ret) begin
                if (w_empty) begin
                    w_pc_nxt  = w_pc_inc;
                    w_unf_set = 1'b1;
                end else begin
                    w_pc_nxt  = r_stk[r_lvl - LW'(1)];
                    w_lvl_nxt = r_lvl - LW'(1);
                end
                if (reti) begin
                    w_state_nxt = ST_RUN;
                end
            end else if (call) begin
                w_push   = 1'b1;
                w_pc_nxt = tgt;
            end else if (jmp) begin
                w_pc_nxt = tgt;
            end else if (r_state == ST_RUN && w_elig != '0) begin
                w_push      = 1'b1;
                w_pc_nxt    = w_vec;
                w_state_nxt = ST_ISR;
                w_ack_nxt   = w_sel;
            end else begin
                w_pc_nxt = w_pc_inc;
            end
        end

        // A push onto a full stack is dropped; the PC still takes its new value.
        if (w_push) begin
            if (w_full) begin
                w_ovf_set = 1'b1;
            end else begin
                w_wr_en   = 1'b1;
                w_lvl_nxt = r_lvl + LW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_RUN;
            r_pc    <= '0;
            r_lvl   <= '0;
            r_req_d <= '0;
            r_pend  <= '0;
            r_ack   <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_lvl   <= w_lvl_nxt;
            r_req_d <= itr_req;
            // Ack of a channel wins over a new edge on that channel.
            r_pend  <= (r_pend | w_edge) & ~w_ack_nxt;
            r_ack   <= w_ack_nxt;
            // clr is not a command, so it acts during stall too; a set event wins.
            r_ovf   <= w_ovf_set | (r_ovf & ~clr);
            r_unf   <= w_unf_set | (r_unf & ~clr);
        end
    end

    // NOTE: stack storage has no reset; entries above r_lvl are never read,
    // so only the occupancy count needs clearing.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_stk[w_wr_idx] <= w_pc_inc;
        end
    end

    assign instr_addr = r_pc;
    assign itr_ack    = r_ack;
    assign itr_busy   = (r_state == ST_ISR);
    assign stk_lvl    = r_lvl;
    assign stk_ovf    = r_ovf;
    assign stk_unf    = r_unf;

endmodule

// File: tb/tb_pc_ctrl_itr.sv
// Self-checking bench for pc_ctrl_itr: directed scenarios with literal
// expectations plus a randomized run compared each cycle to a queue-based model.
module tb_pc_ctrl_itr;

    localparam int MINSTW  = 9;
    localparam int SDEPTH  = 5;
    localparam int NITR    = 4;
    localparam int ITRBASE = 1;
    localparam int ITRSTP  = 2;
    localparam int LW      = $clog2(SDEPTH + 1);

    logic               clk = 1'b0;
    logic               rst;
    logic               stall, jmp, call, ret, reti, clr;
    logic [MINSTW-1:0]  tgt;
    logic [NITR-1:0]    itr_req, itr_mask;
    logic [MINSTW-1:0]  instr_addr;
    logic [NITR-1:0]    itr_ack;
    logic               itr_busy;
    logic [LW-1:0]      stk_lvl;
    logic               stk_ovf, stk_unf;

    pc_ctrl_itr #(
        .MINSTW (MINSTW),
        .SDEPTH (SDEPTH),
        .NITR   (NITR),
        .ITRBASE(ITRBASE),
        .ITRSTP (ITRSTP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .jmp       (jmp),
        .call      (call),
        .ret       (ret),
        .reti      (reti),
        .tgt       (tgt),
        .itr_req   (itr_req),
        .itr_mask  (itr_mask),
        .clr       (clr),
        .instr_addr(instr_addr),
        .itr_ack   (itr_ack),
        .itr_busy  (itr_busy),
        .stk_lvl   (stk_lvl),
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [MINSTW-1:0] m_pc;
    logic [MINSTW-1:0] m_stk[$];
    logic              m_busy, m_ovf, m_unf;
    logic [NITR-1:0]   m_pend, m_prev, m_ack;
    bit                cmp_en = 1'b0;

    function automatic void model_reset();
        m_pc   = '0;
        m_stk.delete();
        m_busy = 1'b0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        m_pend = '0;
        m_prev = '0;
        m_ack  = '0;
    endfunction

    function automatic void model_push(inout bit ovf_ev);
        if (m_stk.size() < SDEPTH) m_stk.push_back(MINSTW'(m_pc + 1));
        else ovf_ev = 1'b1;
    endfunction

    function automatic void model_step();
        logic [NITR-1:0] edges, elig;
        bit ovf_ev, unf_ev;
        int ch;
        edges  = itr_req & ~m_prev;
        elig   = m_pend & ~itr_mask;
        m_prev = itr_req;
        m_ack  = '0;
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        if (!stall) begin
            if (reti || ret) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin
                    m_pc   = MINSTW'(m_pc + 1);
                    unf_ev = 1'b1;
                end
                if (reti) m_busy = 1'b0;
            end else if (call) begin
                model_push(ovf_ev);
                m_pc = tgt;
            end else if (jmp) begin
                m_pc = tgt;
            end else if (!m_busy && elig != '0) begin
                ch = 0;
                while (!elig[ch]) ch++;
                model_push(ovf_ev);
                m_pc   = MINSTW'(ITRBASE + ch * ITRSTP);
                m_busy = 1'b1;
                m_ack  = NITR'(1) << ch;
            end else begin
                m_pc = MINSTW'(m_pc + 1);
            end
        end
        m_pend = (m_pend | edges) & ~m_ack;
        m_ovf  = ovf_ev ? 1'b1 : (clr ? 1'b0 : m_ovf);
        m_unf  = unf_ev ? 1'b1 : (clr ? 1'b0 : m_unf);
    endfunction

    // Compare process: outputs settle after posedge, sampled on negedge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("mdl_addr", 32'(instr_addr), 32'(m_pc));
            check("mdl_ack",  32'(itr_ack),    32'(m_ack));
            check("mdl_busy", 32'(itr_busy),   32'(m_busy));
            check("mdl_lvl",  32'(stk_lvl),    32'(m_stk.size()));
            check("mdl_ovf",  32'(stk_ovf),    32'(m_ovf));
            check("mdl_unf",  32'(stk_unf),    32'(m_unf));
        end
    end

    // Advance one clock; model follows the DUT's sampled inputs, then move 1ns
    // off the edge so new stimulus never races the flops.
    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic idle();
        stall = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0; reti = 1'b0; clr = 1'b0;
    endtask

    task automatic async_reset_now();
        rst = 1'b0;
        model_reset();
        #1;
    endtask

    initial begin
        idle();
        tgt      = '0;
        itr_req  = '0;
        itr_mask = '0;
        rst      = 1'b0;
        model_reset();
        cmp_en   = 1'b1;
        repeat (2) tick();
        check("rst_addr", 32'(instr_addr), 32'd0);
        check("rst_lvl",  32'(stk_lvl),    32'd0);
        check("rst_busy", 32'(itr_busy),   32'd0);
        check("rst_ack",  32'(itr_ack),    32'd0);
        check("rst_ovf",  32'(stk_ovf),    32'd0);
        check("rst_unf",  32'(stk_unf),    32'd0);
        rst = 1'b1;

        // Free run, then asynchronous reset mid-count.
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("free_cnt", 32'(instr_addr), 32'(k));
        end
        async_reset_now();
        check("async_rst_addr", 32'(instr_addr), 32'd0);
        tick();
        rst = 1'b1;

        // Nested call/ret.
        jmp = 1'b1; tgt = 9'd10; tick(); jmp = 1'b0;
        check("jmp10", 32'(instr_addr), 32'd10);
        call = 1'b1; tgt = 9'd50; tick(); call = 1'b0;
        check("call50_addr", 32'(instr_addr), 32'd50);
        check("call50_lvl",  32'(stk_lvl),    32'd1);
        tick(); tick();
        check("pc52", 32'(instr_addr), 32'd52);
        call = 1'b1; tgt = 9'd80; tick(); call = 1'b0;
        check("call80_lvl", 32'(stk_lvl), 32'd2);
        ret = 1'b1; tick();
        check("ret53", 32'(instr_addr), 32'd53);
        tick(); ret = 1'b0;
        check("ret11_addr", 32'(instr_addr), 32'd11);
        check("ret11_lvl",  32'(stk_lvl),    32'd0);

        // Overflow / underflow and clear.
        call = 1'b1; tgt = 9'd100;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("ovf_lvl", 32'(stk_lvl), 32'(k > SDEPTH ? SDEPTH : k));
            check("ovf_flag", 32'(stk_ovf), 32'(k > SDEPTH));
        end
        call = 1'b0; ret = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("unf_addr", 32'(instr_addr), (k < 5) ? 32'd101 : (k == 5 ? 32'd12 : 32'd13));
            check("unf_flag", 32'(stk_unf), 32'(k == 6));
        end
        ret = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
        check("clr_ovf", 32'(stk_ovf), 32'd0);
        check("clr_unf", 32'(stk_unf), 32'd0);

        // PC wrap.
        jmp = 1'b1; tgt = 9'd511; tick(); jmp = 1'b0;
        tick();
        check("wrap", 32'(instr_addr), 32'd0);

        // Two channels rise together; lowest wins, the other waits for reti.
        jmp = 1'b1; tgt = 9'd19; tick(); jmp = 1'b0;
        itr_req = 4'b0110; tick();
        check("pend_no_ack", 32'(itr_ack), 32'd0);
        tick();
        check("itr1_ack",  32'(itr_ack),    32'b0010);
        check("itr1_addr", 32'(instr_addr), 32'd3);
        check("itr1_busy", 32'(itr_busy),   32'd1);
        tick();
        check("no_nest", 32'(itr_ack), 32'd0);
        reti = 1'b1; tick(); reti = 1'b0;
        check("reti21", 32'(instr_addr), 32'd21);
        tick();
        check("itr2_ack",  32'(itr_ack),    32'b0100);
        check("itr2_addr", 32'(instr_addr), 32'd5);
        reti = 1'b1; tick(); reti = 1'b0;
        check("reti22", 32'(instr_addr), 32'd22);
        itr_req = '0;

        // Edge during stall + jmp: entry deferred to first free cycle.
        stall = 1'b1; jmp = 1'b1; tgt = 9'd200; itr_req = 4'b0001; tick();
        check("stall_hold", 32'(instr_addr), 32'd22);
        check("stall_ack",  32'(itr_ack),    32'd0);
        stall = 1'b0; tick(); jmp = 1'b0;
        check("jmp_blocks", 32'(itr_ack),    32'd0);
        check("jmp200",     32'(instr_addr), 32'd200);
        tick();
        check("itr0_ack",  32'(itr_ack),    32'b0001);
        check("itr0_addr", 32'(instr_addr), 32'd1);
        reti = 1'b1; tick(); reti = 1'b0;
        check("reti201", 32'(instr_addr), 32'd201);

        // Masked channel waits until unmasked.
        itr_mask = 4'b1000; itr_req = 4'b1001;
        repeat (3) begin
            tick();
            check("masked", 32'(itr_ack), 32'd0);
        end
        itr_mask = '0; tick();
        check("itr3_ack",  32'(itr_ack),    32'b1000);
        check("itr3_addr", 32'(instr_addr), 32'd7);

        // Reset while in service.
        async_reset_now();
        check("rst_isr_busy", 32'(itr_busy),   32'd0);
        check("rst_isr_addr", 32'(instr_addr), 32'd0);
        check("rst_isr_lvl",  32'(stk_lvl),    32'd0);
        itr_req = '0;
        tick();
        rst = 1'b1;
        repeat (3) begin
            tick();
            check("pend_cleared", 32'(itr_ack), 32'd0);
        end

        // Randomized run.
        for (int n = 0; n < 4000; n++) begin
            stall = ($urandom % 8) == 0;
            jmp   = ($urandom % 10) == 0;
            call  = ($urandom % 10) == 0;
            ret   = ($urandom % 12) == 0;
            reti  = ($urandom % 12) == 0;
            clr   = ($urandom % 20) == 0;
            tgt   = MINSTW'($urandom);
            for (int b = 0; b < NITR; b++)
                if (($urandom % 6) == 0) itr_req[b] = ~itr_req[b];
            if (($urandom % 16) == 0) itr_mask = NITR'($urandom);
            if (($urandom % 700) == 0) begin
                async_reset_now();
                #1;
                rst = 1'b1;
            end
            tick();
        end
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
